add4_accumulator: RTL and testbench
===================================

# add4_accumulator

Sequencing and result-register stage wrapped around the 4-bit carry-lookahead adder. It accepts a batch of COUNT 4-bit operands over a valid/ready handshake and drives the adder's A and B inputs from registers. Each adder sum is captured back into a 4-bit accumulator with a sticky carry flag. The finished batch total is presented downstream over a second valid/ready handshake. The adder stays purely combinational; this block supplies all of the sequential behaviour around it.

## Interface
- COUNT, 4: operands per batch; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_data  in  4  operand value.
- in_ready  out  1  block can accept an operand.
- add_a  out  4  to adder A inputs; driven from the accumulator register; bit 0 feeds A1.
- add_b  out  4  to adder B inputs; driven from the operand register; bit 0 feeds B1.
- add_s  in  5  from adder s0..s4; bit 4 is the carry-out.
- out_valid  out  1  batch result valid.
- out_data  out  4  batch result.
- out_carry  out  1  a carry-out occurred at some point in the batch (sticky).
- out_ready  in  1  downstream accepts the result.
- busy  out  1  a batch is in progress (cnt != 0 or state != IDLE).

## Operation
- State machine has three states: IDLE, SUM, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid & in_ready: opnd<=in_data, cnt<=cnt+1, go to SUM.
- **SUM**
  - in_ready=0.
  - acc<=add_s[3:0], carry<=carry|add_s[4].
  - If cnt==COUNT, go to DONE; otherwise go to IDLE.
- **DONE**
  - out_valid=1, out_data=acc, out_carry=carry, in_ready=0.
  - On out_ready: acc<=0, carry<=0, cnt<=0, go to IDLE.
- Arithmetic is 4-bit modulo 16 (wrap) unless the saturation option below is compiled in. The carry flag is sticky in both modes.
- cnt is 4 bits wide and compares equal to COUNT exactly once per batch, so it never wraps.
- in_valid during SUM or DONE is ignored; the upstream source must hold the operand until in_ready.
- out_data and out_carry stay stable for the whole time out_valid is high.
- Reset values:
  - state=IDLE, acc=0, opnd=0, cnt=0, carry=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_carry=0, busy=0, add_a=0, add_b=0.
- Reset asserted mid-batch abandons the batch immediately. No partial result is ever presented.

## Timing
- add_a and add_b are register outputs, stable for the entire SUM cycle. The adder path runs register -> adder -> register in a single cycle; the clock period must exceed the adder's worst-case delay (about 60 ns in the gate-delay model).
- Each operand takes 2 cycles (accept, then sum), so peak throughput is one operand every 2 cycles.
- Latency from the last operand accept to out_valid is 2 cycles. With out_ready held high, the result handshake takes 1 cycle.
- Back-to-back batches: if out_ready is high in DONE, IDLE and in_ready=1 follow on the next cycle. An operand offered during DONE is not taken early.
- The earliest new accept is in the cycle after the result is taken.

## Configuration
- SATURATE_EN defined: in SUM, if add_s[4]=1 or acc is already 4'hF, then acc<=4'hF. The total clamps at 15 and stays there for the rest of the batch.
- SATURATE_EN undefined: acc<=add_s[3:0] (wrap).
- The carry flag behaves identically in both builds.

## Test plan
- Reset, then COUNT=4, operands 1,2,3,4 with no stalls -> out_valid in the 2nd cycle after the 4th accept; out_data=10, out_carry=0; busy falls after the handshake.
- COUNT=4, operands 8,8,1,0 -> wrap build gives out_data=1, out_carry=1; SATURATE_EN build gives out_data=15, out_carry=1.
- in_valid held high continuously -> in_ready toggles 1/0; exactly 4 accepts per batch; add_b equals each operand during its SUM cycle.
- Hold out_ready low for 5 cycles in DONE -> out_valid, out_data and out_carry stay constant; in_ready=0 throughout; no operand is consumed.
- Assert rst_n low after 2 of 4 operands -> all outputs return to their reset values asynchronously. The next batch 5,5,5,5 gives out_data=4 (wrap) or 15 (sat), out_carry=1.
- COUNT=1, operand 15 -> out_data=15, out_carry=0, out_valid 2 cycles after the accept.

Source files
------------

// File: rtl/add4_accumulator.sv
// add4_accumulator
//   Sequencing and result register stage around an external, purely
//   combinational 4-bit carry-lookahead adder. Accepts COUNT operands over a
//   valid/ready handshake and feeds the adder from registers: A comes from the
//   accumulator and B from the operand register. Each sum is captured back
//   into the accumulator, with a sticky carry flag. The batch total is then
//   offered downstream over a second valid/ready handshake.
//
//   Optional build macro: SATURATE_EN clamps the running total at 4'hF
//   instead of letting it wrap modulo 16. The carry flag is sticky in both
//   builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand present
//   in_data    in   [3:0] operand value
//   in_ready   out  block can accept an operand
//   add_a      out  [3:0] adder A inputs (accumulator register, bit 0 = A1)
//   add_b      out  [3:0] adder B inputs (operand register, bit 0 = B1)
//   add_s      in   [4:0] adder s0..s4, bit 4 is the carry-out
//   out_valid  out  batch result valid
//   out_data   out  [3:0] batch result
//   out_carry  out  sticky carry-out seen during the batch
//   out_ready  in   downstream accepts the result
//   busy       out  a batch is in progress
module add4_accumulator #(
  parameter int unsigned COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [4:0] add_s,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_carry,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] COUNT_W = 4'(COUNT);

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] acc;
  logic [3:0] opnd;
  logic [3:0] cnt;
  logic       carry;
  logic [3:0] sum_val;
  logic       accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SUM;
      SUM:     state_nxt = (cnt == COUNT_W) ? DONE : IDLE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_carry = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      SUM:  ;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_carry = carry;
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (cnt != '0) || (state != IDLE);
  assign add_a  = acc;
  assign add_b  = opnd;

  // Value written into the accumulator in SUM
`ifdef SATURATE_EN
  always_comb begin
    sum_val = add_s[3:0];
    if (add_s[4] || (acc == 4'hF)) sum_val = 4'hF;
  end
`else
  assign sum_val = add_s[3:0];
`endif

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      if (accept) begin
        opnd <= in_data;
        cnt  <= cnt + 4'd1;
      end
      if (state == SUM) begin
        acc   <= sum_val;
        carry <= carry | add_s[4];
      end
      if ((state == DONE) && out_ready) begin
        acc   <= '0;
        carry <= 1'b0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add4_accumulator.sv
module tb_add4_accumulator;

  localparam int NOPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // COUNT=4 instance
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic [3:0] add_a, add_b;
  logic [4:0] add_s;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_carry;
  logic       out_ready = 1'b0;
  logic       busy;

  // COUNT=1 instance
  logic       in_valid1 = 1'b0;
  logic [3:0] in_data1 = '0;
  logic       in_ready1;
  logic [3:0] add_a1, add_b1;
  logic [4:0] add_s1;
  logic       out_valid1;
  logic [3:0] out_data1;
  logic       out_carry1;
  logic       out_ready1 = 1'b0;
  logic       busy1;

  int errors = 0;
  int checks = 0;

  // External combinational adders
  assign add_s  = {1'b0, add_a}  + {1'b0, add_b};
  assign add_s1 = {1'b0, add_a1} + {1'b0, add_b1};

  add4_accumulator #(.COUNT(NOPS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .out_valid(out_valid), .out_data(out_data), .out_carry(out_carry),
    .out_ready(out_ready), .busy(busy)
  );

  add4_accumulator #(.COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .add_a(add_a1), .add_b(add_b1), .add_s(add_s1),
    .out_valid(out_valid1), .out_data(out_data1), .out_carry(out_carry1),
    .out_ready(out_ready1), .busy(busy1)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Running total of a batch as the accumulator should hold it
  function automatic int clamp(input int s);
`ifdef SATURATE_EN
    return (s > 15) ? 15 : s;
`else
    return s % 16;
`endif
  endfunction

  // Reference model and per-cycle compare for the COUNT=4 instance
  int       m_sum = 0;
  int       m_before = 0;
  int       m_n = 0;
  bit       m_prev_acc = 1'b0;
  bit       m_valid = 1'b0;
  int       m_last = 0;

  always @(negedge clk) begin
    bit exp_ready;
    bit pa;
    if (!rst_n) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_add_a", int'(add_a), 0);
      chk("rst_add_b", int'(add_b), 0);
      m_sum = 0; m_before = 0; m_n = 0; m_prev_acc = 1'b0; m_valid = 1'b0;
    end else begin
      exp_ready = !m_prev_acc && !m_valid;
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("busy", int'(busy), int'((m_n != 0) || m_prev_acc || m_valid));
      if (m_prev_acc) begin
        chk("add_b", int'(add_b), m_last);
        chk("add_a", int'(add_a), clamp(m_before));
      end
      if (m_valid) begin
        chk("out_data", int'(out_data), clamp(m_sum));
        chk("out_carry", int'(out_carry), int'(m_sum >= 16));
      end
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0; m_sum = 0; m_n = 0;
        end
      end else if (m_prev_acc && (m_n == NOPS)) begin
        m_valid = 1'b1;
      end
      pa = exp_ready && in_valid;
      if (pa) begin
        m_before = m_sum;
        m_last   = int'(in_data);
        m_sum    = m_sum + int'(in_data);
        m_n++;
      end
      m_prev_acc = pa;
    end
  end

  task automatic send_op(input logic [3:0] v, input bit keep);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input bit lit, input int ed, input int ec, input int stall);
    bit seen = 1'b0;
    if (stall == 0) out_ready = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("result_timeout", 0, 1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      return;
    end
    if (lit) begin
      chk("lit_out_data", int'(out_data), ed);
      chk("lit_out_carry", int'(out_carry), ec);
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic batch(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input bit keep, input bit lit, input int ed,
                       input int ec, input int stall);
    send_op(a, keep);
    send_op(b, keep);
    send_op(c, keep);
    send_op(d, keep);
    get_result(lit, ed, ec, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_in_ready", int'(in_ready), 1);
    chk("init_out_carry", int'(out_carry), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic batch, no stalls
    batch(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 10, 0, 0);
    @(posedge clk); #1;

    // Overflow batch
`ifdef SATURATE_EN
    batch(4'd8, 4'd8, 4'd1, 4'd0, 1'b0, 1'b1, 15, 1, 0);
`else
    batch(4'd8, 4'd8, 4'd1, 4'd0, 1'b0, 1'b1, 1, 1, 0);
`endif

    // in_valid held high throughout, 5-cycle stall in DONE
`ifdef SATURATE_EN
    batch(4'd3, 4'd6, 4'd9, 4'd12, 1'b1, 1'b1, 15, 1, 5);
`else
    batch(4'd3, 4'd6, 4'd9, 4'd12, 1'b1, 1'b1, 14, 1, 5);
`endif

    // Reset in the middle of a batch
    send_op(4'd7, 1'b0);
    send_op(4'd9, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", int'(in_ready), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_add_a", int'(add_a), 0);
    chk("async_add_b", int'(add_b), 0);
    chk("async_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef SATURATE_EN
    batch(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 15, 1, 0);
`else
    batch(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 4, 1, 0);
`endif

    // COUNT=1 instance, single operand 15
    in_valid1 = 1'b1;
    in_data1  = 4'd15;
    @(negedge clk);
    chk("c1_in_ready", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("c1_sum_valid", int'(out_valid1), 0);
    chk("c1_add_b", int'(add_b1), 15);
    chk("c1_busy", int'(busy1), 1);
    @(negedge clk);
    chk("c1_out_valid", int'(out_valid1), 1);
    chk("c1_out_data", int'(out_data1), 15);
    chk("c1_out_carry", int'(out_carry1), 0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    @(negedge clk);
    chk("c1_after_valid", int'(out_valid1), 0);
    chk("c1_after_busy", int'(busy1), 0);
    chk("c1_after_ready", int'(in_ready1), 1);

    // Randomized batches with gaps and stalls
    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < NOPS; k++) begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        send_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      get_result(1'b0, 0, 0, $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
